loader_ctrl: RTL and testbench
==============================

LOADER_CTRL -- requirements
Module: loader_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-003 SHALL have ports rx_data (input, 8): host command byte; rx_valid (input, 1): byte offered; rx_ready (output, 1): byte accepted when rx_valid && rx_ready.
REQ-004 SHALL have ports tx_data (output, 8): response byte; tx_valid (output, 1): byte offered; tx_ready (input, 1): byte taken when tx_valid && tx_ready.
REQ-005 SHALL have ports prog_we (output, 1), prog_addr (output, 8), prog_wdata (output, 8): program RAM write port.
REQ-006 SHALL have ports data_we (output, 1), data_re (output, 1), data_addr (output, 8), data_wdata (output, 8), data_rdata (input, 8): data RAM port; data_rdata valid the cycle after data_re.
REQ-007 SHALL have port cpu_reset, output, 1: reset to the target CPU; 1 holds it in reset.

Function
REQ-008 SHALL decode, in IDLE, command bytes 0x50 'P' (program write), 0x44 'D' (data write), 0x52 'R' (data read), 0x47 'G' (set cpu_reset); any other byte SHALL be answered with 0x3F and the FSM SHALL return to IDLE.
REQ-009 SHALL have states IDLE, ADDR, LEN, WDATA, RREQ, RWAIT, RSEND, GARG, RESP.
REQ-010 SHALL take P/D/R from IDLE to ADDR, then LEN; G SHALL go from IDLE to GARG.
REQ-011 SHALL latch a start address in ADDR and a count in LEN; count 0 means 256 bytes.
REQ-012 SHALL, in WDATA, write each accepted byte to the current address, then increment the address modulo 256 (0xFF wraps to 0x00).
REQ-013 SHALL assert prog_we or data_we as a one-cycle pulse in the cycle after the byte handshake, with address and wdata stable in that cycle.
REQ-014 SHALL, after the last payload byte, enter RESP and send 0x21.
REQ-015 SHALL, when P or D is received while cpu_reset=0, still consume address, count and payload bytes but issue no write strobes, and SHALL answer 0x23 instead of 0x21.
REQ-016 SHALL, for R, loop RREQ (data_re pulse), then RWAIT (capture data_rdata), then RSEND (tx_valid held with the captured byte until tx_ready), for count bytes, with the address wrapping as in REQ-012; R sends no trailing 0x21.
REQ-017 SHALL, in GARG, set cpu_reset to bit 0 of the accepted byte in the cycle after acceptance, then send 0x21.
REQ-018 SHALL drive rx_ready=1 only in IDLE, ADDR, LEN, WDATA and GARG, and SHALL drive rx_ready=0 while tx_valid=1.
REQ-019 SHALL hold tx_data stable while tx_valid=1 and tx_ready=0, and SHALL deassert tx_valid in the cycle after the handshake.
REQ-020 SHALL never assert prog_we, data_we and data_re in the same cycle; at most one strobe SHALL be high per cycle.
REQ-021 SHALL not accept a new command until the response for the current one has been taken; RESP returns to IDLE on tx handshake.

Reset
REQ-022 SHALL, on reset, force state IDLE, cpu_reset=1, rx_ready=0 in the reset cycle, tx_valid=0, prog_we=0, data_we=0, data_re=0, addresses=0, tx_data=0 and the count=0.
REQ-023 SHALL abort an in-progress command on reset mid-operation, issuing no further strobe or response byte.
REQ-024 SHALL reach IDLE with rx_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-025 SHALL, with LOADER_READBACK_EN defined, implement R and states RREQ, RWAIT and RSEND as above.
REQ-026 SHALL, without LOADER_READBACK_EN, treat 0x52 as an unknown command (answer 0x3F), omit the RREQ, RWAIT and RSEND logic, and tie data_re to 0.

Verification
REQ-027 Bench: reset, then G 0x00 -> cpu_reset stays 1 until the G argument is accepted, then 0; response 0x21.
REQ-028 Bench: reset, P 0xFE 0x03 then AA BB CC -> prog_we pulses at 0xFE, 0xFF and 0x00 with AA, BB and CC; then 0x21.
REQ-029 Bench: G 0x00, then D 0x10 0x01 0x55 -> no data_we; response 0x23; next command accepted normally.
REQ-030 Bench: with LOADER_READBACK_EN, D 0x20 0x02 11 22, then R 0x20 0x02 with tx_ready low 5 cycles -> tx_data 0x11 held, then 0x22; no extra byte.
REQ-031 Bench: byte 0x7A -> response 0x3F; without LOADER_READBACK_EN, byte 0x52 -> response 0x3F.
REQ-032 Bench: reset asserted after 2 of 4 payload bytes of a D command -> no further data_we, tx_valid=0, cpu_reset=1, then IDLE.

Source files
------------

// File: rtl/loader_ctrl.sv
// loader_ctrl: byte-command loader for a target CPU's program/data RAMs.
// Optional feature: define LOADER_READBACK_EN to enable the 'R' data-read command.
module loader_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       prog_we,
  output logic [7:0] prog_addr,
  output logic [7:0] prog_wdata,
  output logic       data_we,
  output logic       data_re,
  output logic [7:0] data_addr,
  output logic [7:0] data_wdata,
  input  logic [7:0] data_rdata,
  output logic       cpu_reset
);

  localparam logic [7:0] CMD_P    = 8'h50;
  localparam logic [7:0] CMD_D    = 8'h44;
  localparam logic [7:0] CMD_G    = 8'h47;
  localparam logic [7:0] RSP_OK   = 8'h21;
  localparam logic [7:0] RSP_LOCK = 8'h23;
  localparam logic [7:0] RSP_BAD  = 8'h3F;
`ifdef LOADER_READBACK_EN
  localparam logic [7:0] CMD_R    = 8'h52;
`endif

  typedef enum logic [3:0] {
    IDLE, ADDR, LEN, WDATA, RREQ, RWAIT, RSEND, GARG, RESP
  } state_t;

  state_t     state;
  logic [7:0] addr;
  logic [7:0] cnt;
  logic       cmd_prog;
  logic       wr_en;
  logic       rx_hs;
  logic       last;

  assign rx_hs = rx_valid && rx_ready;
  assign last  = (cnt == 8'd1);

`ifdef LOADER_READBACK_EN
  logic cmd_read;
`else
  logic rdata_unused;
  assign rdata_unused = ^data_rdata;
  assign data_re      = 1'b0;
`endif

  // Command FSM; every output is set on the transition into the state that owns it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cpu_reset  <= 1'b1;
      rx_ready   <= 1'b0;
      tx_valid   <= 1'b0;
      tx_data    <= 8'h00;
      prog_we    <= 1'b0;
      prog_addr  <= 8'h00;
      prog_wdata <= 8'h00;
      data_we    <= 1'b0;
      data_addr  <= 8'h00;
      data_wdata <= 8'h00;
      addr       <= 8'h00;
      cnt        <= 8'h00;
      cmd_prog   <= 1'b0;
      wr_en      <= 1'b0;
`ifdef LOADER_READBACK_EN
      data_re    <= 1'b0;
      cmd_read   <= 1'b0;
`endif
    end else begin
      prog_we <= 1'b0;
      data_we <= 1'b0;
`ifdef LOADER_READBACK_EN
      data_re <= 1'b0;
`endif
      case (state)
        IDLE: begin
          rx_ready <= 1'b1;
          if (rx_hs) begin
            cmd_prog <= (rx_data == CMD_P);
            wr_en    <= cpu_reset;
`ifdef LOADER_READBACK_EN
            cmd_read <= (rx_data == CMD_R);
`endif
            case (rx_data)
              CMD_P, CMD_D: state <= ADDR;
`ifdef LOADER_READBACK_EN
              CMD_R:        state <= ADDR;
`endif
              CMD_G:        state <= GARG;
              default: begin
                state    <= RESP;
                rx_ready <= 1'b0;
                tx_valid <= 1'b1;
                tx_data  <= RSP_BAD;
              end
            endcase
          end
        end
        ADDR: if (rx_hs) begin
          addr  <= rx_data;
          state <= LEN;
        end
        LEN: if (rx_hs) begin
          cnt   <= rx_data;
          state <= WDATA;
`ifdef LOADER_READBACK_EN
          if (cmd_read) begin
            state     <= RREQ;
            rx_ready  <= 1'b0;
            data_re   <= 1'b1;
            data_addr <= addr;
            addr      <= addr + 8'd1;
          end
`endif
        end
        WDATA: if (rx_hs) begin
          // Locked writes still walk the address so the stream stays in sync.
          if (cmd_prog) begin
            prog_addr  <= addr;
            prog_wdata <= rx_data;
            prog_we    <= wr_en;
          end else begin
            data_addr  <= addr;
            data_wdata <= rx_data;
            data_we    <= wr_en;
          end
          addr <= addr + 8'd1;
          cnt  <= cnt - 8'd1;
          if (last) begin
            state    <= RESP;
            rx_ready <= 1'b0;
            tx_valid <= 1'b1;
            tx_data  <= wr_en ? RSP_OK : RSP_LOCK;
          end
        end
`ifdef LOADER_READBACK_EN
        RREQ: state <= RWAIT;
        RWAIT: begin
          tx_data  <= data_rdata;
          tx_valid <= 1'b1;
          state    <= RSEND;
        end
        RSEND: if (tx_valid && tx_ready) begin
          tx_valid <= 1'b0;
          cnt      <= cnt - 8'd1;
          if (last) begin
            state    <= IDLE;
            rx_ready <= 1'b1;
          end else begin
            state     <= RREQ;
            data_re   <= 1'b1;
            data_addr <= addr;
            addr      <= addr + 8'd1;
          end
        end
`endif
        GARG: if (rx_hs) begin
          cpu_reset <= rx_data[0];
          state     <= RESP;
          rx_ready  <= 1'b0;
          tx_valid  <= 1'b1;
          tx_data   <= RSP_OK;
        end
        RESP: if (tx_valid && tx_ready) begin
          tx_valid <= 1'b0;
          rx_ready <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_loader_ctrl.sv
// Directed self-checking bench for loader_ctrl (readback tests run when LOADER_READBACK_EN is defined).
module tb_loader_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       prog_we;
  logic [7:0] prog_addr;
  logic [7:0] prog_wdata;
  logic       data_we;
  logic       data_re;
  logic [7:0] data_addr;
  logic [7:0] data_wdata;
  logic [7:0] data_rdata;
  logic       cpu_reset;

  int checks = 0;
  int errors = 0;
  int multi_strobe = 0;
  int re_cnt = 0;
  int tx_cnt = 0;
  logic [15:0] prog_q[$];
  logic [15:0] dw_q[$];
  logic [7:0]  mem [256];

  loader_ctrl dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .data_we(data_we), .data_re(data_re), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .cpu_reset(cpu_reset)
  );

  always #5 clk = ~clk;

  // Data RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (data_we) mem[data_addr] <= data_wdata;
    if (data_re) data_rdata <= mem[data_addr];
    if (tx_valid && tx_ready) tx_cnt <= tx_cnt + 1;
  end

  always @(negedge clk) begin
    if (prog_we) prog_q.push_back({prog_addr, prog_wdata});
    if (data_we) dw_q.push_back({data_addr, data_wdata});
    if (data_re) re_cnt++;
    if ((32'(prog_we) + 32'(data_we) + 32'(data_re)) > 1) multi_strobe++;
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      checks++;
      errors++;
      $display("FAIL send_byte: rx_ready timeout, got %b want 1 (byte %h)", rx_ready, b);
    end
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic recv_expect(input string name, input logic [7:0] exp, input int stall);
    int n = 0;
    tx_ready = 1'b0;
    @(negedge clk);
    while (!tx_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tx_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s: tx_valid timeout, got %b want 1", name, tx_valid);
    end else begin
      checks++;
      if (tx_data !== exp) begin
        errors++;
        $display("FAIL %s: tx_data got %h want %h", name, tx_data, exp);
      end
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== exp || rx_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s_hold: valid/data/rx_ready got %b/%h/%b want 1/%h/0",
                   name, tx_valid, tx_data, rx_ready, exp);
        end
      end
      tx_ready = 1'b1;
      @(posedge clk);
      #1 tx_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (tx_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s_drop: tx_valid got %b want 0", name, tx_valid);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({rx_ready, tx_valid, cpu_reset, prog_we, data_we, data_re} !== 6'b001000) begin
      errors++;
      $display("FAIL reset_ctl: rdy/tv/cpu/pwe/dwe/dre got %b want 001000",
               {rx_ready, tx_valid, cpu_reset, prog_we, data_we, data_re});
    end
    checks++;
    if ({tx_data, prog_addr, data_addr} !== 24'h0) begin
      errors++;
      $display("FAIL reset_data: tx_data/prog_addr/data_addr got %h want 000000",
               {tx_data, prog_addr, data_addr});
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: rx_ready got %b want 1", rx_ready);
    end
  endtask

  task automatic test_program();
    logic [15:0] exp [3];
    exp[0] = 16'hFEAA; exp[1] = 16'hFFBB; exp[2] = 16'h00CC;
    prog_q.delete();
    send_byte(8'h50); send_byte(8'hFE); send_byte(8'h03);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    recv_expect("prog_resp", 8'h21, 2);
    checks++;
    if (prog_q.size() != 3) begin
      errors++;
      $display("FAIL prog_count: got %0d want 3", prog_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (prog_q[i] !== exp[i]) begin
          errors++;
          $display("FAIL prog_write%0d: addr/data got %h want %h", i, prog_q[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_count_256();
    prog_q.delete();
    send_byte(8'h50); send_byte(8'h00); send_byte(8'h00);
    for (int i = 0; i < 256; i++) send_byte(8'(255 - i));
    recv_expect("len256_resp", 8'h21, 0);
    checks++;
    if (prog_q.size() != 256) begin
      errors++;
      $display("FAIL len256_count: got %0d want 256", prog_q.size());
    end else begin
      checks++;
      if (prog_q[255] !== 16'hFF00 || prog_q[0] !== 16'h00FF) begin
        errors++;
        $display("FAIL len256_ends: first/last got %h/%h want 00ff/ff00", prog_q[0], prog_q[255]);
      end
    end
  endtask

  task automatic test_go();
    send_byte(8'h47);
    checks++;
    if (cpu_reset !== 1'b1) begin
      errors++;
      $display("FAIL go_before_arg: cpu_reset got %b want 1", cpu_reset);
    end
    send_byte(8'h00);
    checks++;
    if (cpu_reset !== 1'b0) begin
      errors++;
      $display("FAIL go_after_arg: cpu_reset got %b want 0", cpu_reset);
    end
    recv_expect("go_resp", 8'h21, 1);
  endtask

  task automatic test_data_locked();
    dw_q.delete();
    send_byte(8'h44); send_byte(8'h10); send_byte(8'h01); send_byte(8'h55);
    recv_expect("locked_resp", 8'h23, 0);
    checks++;
    if (dw_q.size() != 0) begin
      errors++;
      $display("FAIL locked_no_we: data_we pulses got %0d want 0", dw_q.size());
    end
    send_byte(8'h7A);
    recv_expect("after_locked_resp", 8'h3F, 0);
  endtask

  task automatic test_unknown();
    send_byte(8'h7A);
    recv_expect("unknown_7a", 8'h3F, 3);
`ifndef LOADER_READBACK_EN
    send_byte(8'h52);
    recv_expect("unknown_52", 8'h3F, 0);
`endif
  endtask

`ifdef LOADER_READBACK_EN
  task automatic test_readback();
    int n0;
    dw_q.delete();
    send_byte(8'h44); send_byte(8'h20); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22);
    recv_expect("rb_write_resp", 8'h21, 0);
    checks++;
    if (dw_q.size() != 2 || dw_q[0] !== 16'h2011 || dw_q[1] !== 16'h2122) begin
      errors++;
      $display("FAIL rb_writes: got %0d entries, want 2 (2011,2122)", dw_q.size());
    end
    re_cnt = 0;
    send_byte(8'h52); send_byte(8'h20); send_byte(8'h02);
    recv_expect("rb_byte0", 8'h11, 5);
    recv_expect("rb_byte1", 8'h22, 0);
    n0 = tx_cnt;
    tx_ready = 1'b1;
    for (int i = 0; i < 10; i++) @(negedge clk);
    tx_ready = 1'b0;
    checks++;
    if (tx_cnt != n0 || re_cnt != 2) begin
      errors++;
      $display("FAIL rb_no_extra: extra tx %0d / data_re %0d, want 0 / 2", tx_cnt - n0, re_cnt);
    end
  endtask
`endif

  task automatic test_reset_mid();
    dw_q.delete();
    send_byte(8'h44); send_byte(8'h30); send_byte(8'h04);
    send_byte(8'h01); send_byte(8'h02);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (dw_q.size() != 2) begin
      errors++;
      $display("FAIL mid_pre: data_we pulses got %0d want 2", dw_q.size());
    end
    dw_q.delete();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || cpu_reset !== 1'b1 || rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: tv/cpu/rdy got %b%b%b want 010", tx_valid, cpu_reset, rx_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge clk);
    checks++;
    if (dw_q.size() != 0 || tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_after: we %0d tv %b rdy %b want 0 0 1", dw_q.size(), tx_valid, rx_ready);
    end
    send_byte(8'h7A);
    recv_expect("mid_idle_resp", 8'h3F, 0);
  endtask

  initial begin
    test_reset();
    test_program();
    test_count_256();
    test_go();
    test_data_locked();
    test_reset();
    test_unknown();
`ifdef LOADER_READBACK_EN
    test_readback();
`endif
    test_reset_mid();
    checks++;
    if (multi_strobe != 0) begin
      errors++;
      $display("FAIL strobe_exclusive: overlapping strobe cycles got %0d want 0", multi_strobe);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
